// File: rtl/inst_aligner.sv
// Fetch-side instruction aligner: fetches words, buffers up to three halfwords and
// presents one aligned RV32IC instruction (16- or 32-bit) per decoder handshake.
module inst_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        fetch_req_o,
    output logic [31:0] fetch_addr_o,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_data_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic        is_c_o,
    output logic [31:0] pc_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned HW    = 16;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned CW    = 2;

    logic [HW-1:0]   hw_q [DEPTH];
    logic [HW-1:0]   hw_d [DEPTH];
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] faddr_q, faddr_d;
    logic            freq_q, freq_d;
    logic            drop_q, drop_d;
    logic            skip_q, skip_d;

    logic            head_c_c;
    logic            valid_c;
    logic            pop_c;
    logic            outstanding_c;
    logic            accept_c;
    logic [CW-1:0]   cnt_s_c;
    logic [HW-1:0]   lo_hw_c;
    logic [HW-1:0]   hi_hw_c;

    // Head decode: a compressed head needs one halfword, otherwise two.
    always_comb begin
        head_c_c      = (count_q != CW'(0)) && (hw_q[0][1:0] != 2'b11);
        valid_c       = head_c_c || (count_q >= CW'(2));
        pop_c         = valid_c && inst_ready_i;
        outstanding_c = freq_q || drop_q;
        accept_c      = fetch_valid_i && outstanding_c;
        lo_hw_c       = fetch_data_i[HW-1:0];
        hi_hw_c       = fetch_data_i[XLEN-1:HW];
    end

    assign fetch_req_o  = freq_q;
    assign fetch_addr_o = faddr_q;
    assign pc_o         = pc_q;
    assign inst_valid_o = valid_c;
    assign is_c_o       = head_c_c;
    assign inst_o       = head_c_c ? {16'h0000, hw_q[0]} : {hw_q[1], hw_q[0]};

    // Next state: redirect wins; otherwise shift out the popped instruction, then append at the new tail.
    always_comb begin
        hw_d    = hw_q;
        count_d = count_q;
        pc_d    = pc_q;
        faddr_d = faddr_q;
        freq_d  = freq_q;
        drop_d  = drop_q;
        skip_d  = skip_q;
        cnt_s_c = count_q;

        if (redirect_i) begin
            count_d = '0;
            pc_d    = redirect_pc_i;
            faddr_d = {redirect_pc_i[XLEN-1:2], 2'b00};
            skip_d  = redirect_pc_i[1];
            freq_d  = 1'b0;
            drop_d  = outstanding_c && !fetch_valid_i;
        end else begin
            if (pop_c) begin
                if (head_c_c) begin
                    hw_d[0] = hw_q[1];
                    hw_d[1] = hw_q[2];
                    cnt_s_c = count_q - CW'(1);
                    pc_d    = pc_q + XLEN'(2);
                end else begin
                    hw_d[0] = hw_q[2];
                    cnt_s_c = count_q - CW'(2);
                    pc_d    = pc_q + XLEN'(4);
                end
            end
            count_d = cnt_s_c;

            if (accept_c) begin
                freq_d = 1'b0;
                if (drop_q) begin
                    drop_d = 1'b0;
                end else begin
                    faddr_d = faddr_q + XLEN'(4);
                    skip_d  = 1'b0;
                    if (skip_q) begin
                        case (cnt_s_c)
                            CW'(0):  hw_d[0] = hi_hw_c;
                            CW'(1):  hw_d[1] = hi_hw_c;
                            default: hw_d[2] = hi_hw_c;
                        endcase
                        count_d = cnt_s_c + CW'(1);
                    end else begin
                        case (cnt_s_c)
                            CW'(0): begin
                                hw_d[0] = lo_hw_c;
                                hw_d[1] = hi_hw_c;
                            end
                            CW'(1): begin
                                hw_d[1] = lo_hw_c;
                                hw_d[2] = hi_hw_c;
                            end
                            default: hw_d[2] = lo_hw_c;
                        endcase
                        count_d = cnt_s_c + CW'(2);
                    end
                end
            end else if (!outstanding_c && (count_q <= CW'(1))) begin
                freq_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                hw_q[i] <= '0;
            end
            count_q <= '0;
            pc_q    <= RESET_PC;
            faddr_q <= {RESET_PC[XLEN-1:2], 2'b00};
            freq_q  <= 1'b0;
            drop_q  <= 1'b0;
            skip_q  <= RESET_PC[1];
        end else begin
            hw_q    <= hw_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            faddr_q <= faddr_d;
            freq_q  <= freq_d;
            drop_q  <= drop_d;
            skip_q  <= skip_d;
        end
    end

endmodule

// File: tb/tb_inst_aligner.sv
// Scoreboard bench for inst_aligner: behavioural instruction memory plus an
// expected-instruction queue built from the memory image.
module tb_inst_aligner;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        c;
    } exp_t;

    logic        clk;
    logic        rst_n_i;
    logic        fetch_req_o;
    logic [31:0] fetch_addr_o;
    logic        fetch_valid_i;
    logic [31:0] fetch_data_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic        is_c_o;
    logic [31:0] pc_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    inst_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n_i),
        .fetch_req_o  (fetch_req_o),
        .fetch_addr_o (fetch_addr_o),
        .fetch_valid_i(fetch_valid_i),
        .fetch_data_i (fetch_data_i),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_o       (inst_o),
        .is_c_o       (is_c_o),
        .pc_o         (pc_o),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        q[$];
    logic [31:0] mem [128];
    logic        mem_busy;
    logic        mem_drop;
    int          mem_lat;
    logic [31:0] mem_addr;
    logic [31:0] exp_faddr;
    logic        lat_fixed;
    logic [31:0] stall_pc;
    int          stall_left;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] get_hw(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[8:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Expected instruction stream decoded straight from the memory image.
    task automatic push_prog(input logic [31:0] start, input int n);
        logic [31:0] pc;
        logic [15:0] hw;
        exp_t        e;
        pc = start;
        for (int i = 0; i < n; i++) begin
            hw   = get_hw(pc);
            e.pc = pc;
            if (hw[1:0] != 2'b11) begin
                e.inst = {16'h0000, hw};
                e.c    = 1'b1;
                pc     = pc + 32'd2;
            end else begin
                e.inst = {get_hw(pc + 32'd2), hw};
                e.c    = 1'b0;
                pc     = pc + 32'd4;
            end
            q.push_back(e);
        end
    endtask

    task automatic mem_clear();
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    endtask

    // One cycle: memory responder and decoder-side consumer, driven on the falling edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        fetch_valid_i = 1'b0;
        redirect_i    = 1'b0;
        inst_ready_i  = 1'b0;
        if (!mem_busy && fetch_req_o) begin
            check("fetch_addr", fetch_addr_o, exp_faddr);
            mem_addr = fetch_addr_o;
            mem_busy = 1'b1;
            mem_lat  = lat_fixed ? 2 : int'($urandom_range(0, 2));
        end
        if (mem_busy) begin
            if (mem_lat == 0) begin
                fetch_valid_i = 1'b1;
                fetch_data_i  = mem[mem_addr[8:2]];
                mem_busy      = 1'b0;
                if (mem_drop) mem_drop = 1'b0;
                else          exp_faddr = exp_faddr + 32'd4;
            end else begin
                mem_lat--;
            end
        end
        if (inst_valid_o && q.size() > 0) begin
            e = q[0];
            if (stall_left > 0 && e.pc == stall_pc) begin
                check("stall_req", 32'(fetch_req_o), 32'd0);
                check("stall_inst", inst_o, e.inst);
                check("stall_pc", pc_o, e.pc);
                stall_left--;
            end else if ($urandom_range(0, 3) != 0) begin
                inst_ready_i = 1'b1;
                check("inst", inst_o, e.inst);
                check("is_c", 32'(is_c_o), 32'(e.c));
                check("pc", pc_o, e.pc);
                void'(q.pop_front());
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_n_i       = 1'b0;
        fetch_valid_i = 1'b0;
        inst_ready_i  = 1'b0;
        redirect_i    = 1'b0;
        q.delete();
        mem_busy   = 1'b0;
        mem_drop   = 1'b0;
        exp_faddr  = 32'h0;
        stall_left = 0;
        repeat (cycles) @(negedge clk);
        check("rst_valid", 32'(inst_valid_o), 32'd0);
        check("rst_inst", inst_o, 32'h0);
        check("rst_is_c", 32'(is_c_o), 32'd0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_req", 32'(fetch_req_o), 32'd0);
        check("rst_faddr", fetch_addr_o, 32'h0);
        rst_n_i = 1'b1;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_i    = 1'b1;
        redirect_pc_i = target;
        inst_ready_i  = 1'b0;
        if (mem_busy) mem_drop = 1'b1;
        exp_faddr = {target[31:2], 2'b00};
    endtask

    task automatic drain(input int max_cycles);
        int i;
        i = 0;
        while (q.size() != 0 && i < max_cycles) begin
            tick();
            i++;
        end
        check("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        rst_n_i       = 1'b0;
        fetch_valid_i = 1'b0;
        fetch_data_i  = 32'h0;
        inst_ready_i  = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        lat_fixed     = 1'b0;
        stall_pc      = 32'h0;
        stall_left    = 0;
        mem_busy      = 1'b0;
        mem_drop      = 1'b0;
        mem_lat       = 0;
        mem_addr      = 32'h0;
        exp_faddr     = 32'h0;

        // Single 32-bit instruction and fetch-to-valid latency.
        mem_clear();
        mem[0] = 32'h00A0_0093;
        do_reset(2);
        push_prog(32'h0, 1);
        i = 0;
        while (fetch_valid_i !== 1'b1 && i < 20) begin
            tick();
            i++;
        end
        check("lat_wait", 32'(fetch_valid_i), 32'd1);
        tick();
        check("lat_valid", 32'(inst_valid_o), 32'd1);
        drain(50);

        // Two compressed instructions in one word.
        mem_clear();
        mem[0] = 32'h4505_4485;
        do_reset(1);
        push_prog(32'h0, 2);
        drain(50);
        check("next_faddr", fetch_addr_o, 32'h4);

        // Straddling 32-bit instruction, with a decoder stall while the buffer is full.
        mem_clear();
        mem[0] = 32'h0093_4485;
        mem[1] = 32'h4505_00A0;
        do_reset(1);
        push_prog(32'h0, 3);
        stall_pc   = 32'h2;
        stall_left = 5;
        drain(60);
        check("stall_done", 32'(stall_left), 32'd0);

        // Redirect to a halfword-aligned target while a fetch is outstanding.
        mem_clear();
        mem[0]  = 32'h8001_8001;
        mem[65] = 32'h4505_1234;
        mem[66] = 32'h00A0_0093;
        lat_fixed = 1'b1;
        do_reset(1);
        i = 0;
        while (!(mem_busy && mem_lat > 0) && i < 20) begin
            tick();
            i++;
        end
        check("redir_wait", 32'(mem_busy), 32'd1);
        do_redirect(32'h106);
        push_prog(32'h106, 2);
        tick();
        check("redir_faddr", fetch_addr_o, 32'h104);
        check("redir_valid", 32'(inst_valid_o), 32'd0);
        check("redir_req", 32'(fetch_req_o), 32'd0);
        lat_fixed = 1'b0;
        drain(60);

        // Reset in the middle of a stream restarts fetch at the reset PC.
        mem_clear();
        mem[0] = 32'h4505_4485;
        mem[1] = 32'h00A0_0093;
        mem[2] = 32'h0001_4485;
        do_reset(1);
        push_prog(32'h0, 5);
        repeat (6) tick();
        do_reset(1);
        push_prog(32'h0, 5);
        drain(80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
